// File: rtl/bp_be_pkg.sv
// bp_be_pkg
//
// Shared definitions for the backend stride detector:
//   bp_params_e           processor configuration selector
//   bp_vaddr_width()      virtual-address width for a configuration
//   bp_page_offset_width_gp  page-offset bits (4 KiB pages)
//   bp_be_stride_state_e  detector FSM states
package bp_be_pkg;

    typedef enum logic [0:0] {
        e_bp_default_cfg,
        e_bp_sv32_cfg
    } bp_params_e;

    localparam int unsigned bp_page_offset_width_gp = 12;

    function automatic int unsigned bp_vaddr_width(bp_params_e cfg);
        int unsigned width;
        case (cfg)
            e_bp_sv32_cfg: width = 32;
            default:       width = 39;
        endcase
        return width;
    endfunction

    typedef enum logic [1:0] {
        StIdle,
        StTrain,
        StWaitIter,
        StPrefetch
    } bp_be_stride_state_e;

endpackage

// File: rtl/bp_be_stride_addr_gen.sv
// bp_be_stride_addr_gen
//
// Prefetch address generator: addr_o = last_i + k_i * stride_i, wrapping
// modulo 2^vaddr_width_p.
//
// Build option: when BP_BE_STRIDE_PAGE_CLAMP_EN is defined, page_cross_o
// flags an address whose page number (bits above the page offset) differs
// from last_i's; otherwise page_cross_o is tied low.
//
// Ports:
//   last_i        last trained load address
//   stride_i      confirmed stride
//   k_i           prefetch index (1-based)
//   addr_o        generated prefetch address
//   page_cross_o  generated address leaves last_i's page (clamp builds only)
module bp_be_stride_addr_gen
    import bp_be_pkg::*;
#(
    parameter int unsigned vaddr_width_p = 39,
    parameter int unsigned k_width_p     = 3
) (
    input  logic [vaddr_width_p-1:0] last_i,
    input  logic [vaddr_width_p-1:0] stride_i,
    input  logic [k_width_p-1:0]     k_i,
    output logic [vaddr_width_p-1:0] addr_o,
    output logic                     page_cross_o
);

    logic [vaddr_width_p-1:0] k_ext;
    logic [vaddr_width_p-1:0] offset;

    assign k_ext  = vaddr_width_p'(k_i);
    // Product truncated to the address width: wrap-around is intended.
    assign offset = k_ext * stride_i;
    assign addr_o = last_i + offset;

`ifdef BP_BE_STRIDE_PAGE_CLAMP_EN
    assign page_cross_o = addr_o[vaddr_width_p-1:bp_page_offset_width_gp]
                       != last_i[vaddr_width_p-1:bp_page_offset_width_gp];
`else
    assign page_cross_o = 1'b0;
`endif

endmodule

// File: rtl/bp_be_stride_detector.sv
// bp_be_stride_detector
//
// Watches committed loads, trains on one load PC at a time and, once the
// same non-zero stride has repeated confirm_threshold_p times, asks the
// front end for the remaining loop iteration count and issues up to
// max_prefetch_p prefetches at last + k*stride.
//
// Build option: BP_BE_STRIDE_PAGE_CLAMP_EN (see bp_be_stride_addr_gen) stops
// prefetching at the first address that leaves the trained load's page.
//
// Ports:
//   clk_i, reset_i           clock, asynchronous active-high reset
//   load_v_i/pc_i/vaddr_i    committed load stream
//   flush_i                  abort current training / prefetch run
//   start_discovery_o        one-cycle pulse: new stride candidate
//   confirm_discovery_o      one-cycle pulse: stride confirmed
//   striding_pc_o            PC being trained
//   iter_v_i, remaining_iterations_i, iter_yumi_o  iteration count handshake
//   pf_v_o, pf_vaddr_o, pf_ready_i                 prefetch request handshake
//   busy_o                   detector not idle
module bp_be_stride_detector
    import bp_be_pkg::*;
#(
    parameter bp_params_e  bp_params_p         = e_bp_default_cfg,
    parameter int unsigned iter_width_p        = 8,
    parameter int unsigned confirm_threshold_p = 2,
    parameter int unsigned max_prefetch_p      = 4,
    localparam int unsigned vaddr_width_p      = bp_vaddr_width(bp_params_p)
) (
    input  logic                     clk_i,
    input  logic                     reset_i,

    input  logic                     load_v_i,
    input  logic [vaddr_width_p-1:0] load_pc_i,
    input  logic [vaddr_width_p-1:0] load_vaddr_i,
    input  logic                     flush_i,

    output logic                     start_discovery_o,
    output logic                     confirm_discovery_o,
    output logic [vaddr_width_p-1:0] striding_pc_o,

    input  logic                     iter_v_i,
    input  logic [iter_width_p-1:0]  remaining_iterations_i,
    output logic                     iter_yumi_o,

    output logic                     pf_v_o,
    output logic [vaddr_width_p-1:0] pf_vaddr_o,
    input  logic                     pf_ready_i,

    output logic                     busy_o
);

    localparam int unsigned cnt_width_lp = $clog2(confirm_threshold_p + 1);
    localparam int unsigned k_width_lp   =
        (max_prefetch_p > 0) ? $clog2(max_prefetch_p + 1) : 1;

    localparam logic [cnt_width_lp-1:0] confirm_cnt_lp = cnt_width_lp'(confirm_threshold_p);
    localparam logic [k_width_lp-1:0]   max_pf_lp      = k_width_lp'(max_prefetch_p);

    bp_be_stride_state_e      state_r;
    logic [vaddr_width_p-1:0] pc_r;
    logic [vaddr_width_p-1:0] last_r;
    logic [vaddr_width_p-1:0] stride_r;
    logic [cnt_width_lp-1:0]  cnt_r;
    logic [k_width_lp-1:0]    n_r;
    logic [k_width_lp-1:0]    k_r;
    logic                     drop_r;
    logic                     start_r;
    logic                     confirm_r;

    logic [vaddr_width_p-1:0] stride_s;
    logic                     train_hit;
    logic                     stride_repeat;
    logic [cnt_width_lp-1:0]  cnt_inc;
    logic [31:0]              iter_cnt_ext;
    logic [k_width_lp-1:0]    n_capture;
    logic                     page_cross;

    // Stride of the current load relative to the previous trained load.
    assign stride_s      = load_vaddr_i - last_r;
    assign train_hit     = (state_r == StTrain) && load_v_i && (load_pc_i == pc_r);
    assign stride_repeat = (stride_s != '0) && (stride_s == stride_r);
    assign cnt_inc       = cnt_r + cnt_width_lp'(1);

    // Clamp the offered iteration count to the per-loop prefetch budget.
    assign iter_cnt_ext = 32'(remaining_iterations_i);
    assign n_capture    = (iter_cnt_ext > 32'(max_prefetch_p)) ? max_pf_lp
                                                               : k_width_lp'(iter_cnt_ext);

    bp_be_stride_addr_gen #(
        .vaddr_width_p (vaddr_width_p),
        .k_width_p     (k_width_lp)
    ) u_addr_gen (
        .last_i       (last_r),
        .stride_i     (stride_r),
        .k_i          (k_r),
        .addr_o       (pf_vaddr_o),
        .page_cross_o (page_cross)
    );

    // Handshake outputs are combinational so flush or reset removes the
    // request in the same cycle.
    assign iter_yumi_o = (state_r == StWaitIter) && iter_v_i;
    assign pf_v_o      = (state_r == StPrefetch) && !flush_i && !page_cross;

    assign start_discovery_o   = start_r;
    assign confirm_discovery_o = confirm_r;
    assign striding_pc_o       = pc_r;
    assign busy_o              = (state_r != StIdle);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_r   <= StIdle;
            pc_r      <= '0;
            last_r    <= '0;
            stride_r  <= '0;
            cnt_r     <= '0;
            n_r       <= '0;
            k_r       <= '0;
            drop_r    <= 1'b0;
            start_r   <= 1'b0;
            confirm_r <= 1'b0;
        end else begin
            start_r   <= 1'b0;
            confirm_r <= 1'b0;

            unique case (state_r)
                StIdle: begin
                    if (load_v_i) begin
                        pc_r     <= load_pc_i;
                        last_r   <= load_vaddr_i;
                        stride_r <= '0;
                        cnt_r    <= '0;
                        state_r  <= StTrain;
                    end
                end

                StTrain: begin
                    if (flush_i) begin
                        state_r <= StIdle;
                    end else if (train_hit) begin
                        last_r <= load_vaddr_i;
                        if (stride_repeat) begin
                            cnt_r <= cnt_inc;
                            if (cnt_inc == confirm_cnt_lp) begin
                                confirm_r <= 1'b1;
                                state_r   <= StWaitIter;
                            end
                        end else begin
                            // A zero stride resets training without
                            // announcing a new candidate.
                            stride_r <= stride_s;
                            cnt_r    <= '0;
                            start_r  <= (stride_s != '0);
                        end
                    end
                end

                StWaitIter: begin
                    if (flush_i) begin
                        drop_r <= 1'b1;
                    end
                    if (iter_v_i) begin
                        drop_r <= 1'b0;
                        n_r    <= n_capture;
                        k_r    <= k_width_lp'(1);
                        if (drop_r || flush_i || (n_capture == '0)) begin
                            state_r <= StIdle;
                        end else begin
                            state_r <= StPrefetch;
                        end
                    end
                end

                StPrefetch: begin
                    if (flush_i || page_cross) begin
                        state_r <= StIdle;
                    end else if (pf_ready_i) begin
                        k_r <= k_r + k_width_lp'(1);
                        if (k_r == n_r) begin
                            state_r <= StIdle;
                        end
                    end
                end

                default: state_r <= StIdle;
            endcase
        end
    end

endmodule

// File: doc/bp_be_stride_detector.md
BP_BE_STRIDE_DETECTOR -- requirements
Module: bp_be_stride_detector

Interface
REQ-001 SHALL have parameter bp_params_p, default e_bp_default_cfg, the processor configuration supplying vaddr_width_p.
REQ-002 SHALL have parameter iter_width_p, default 8, the width of the remaining-iteration count.
REQ-003 SHALL have parameter confirm_threshold_p, default 2, the number of consecutive repeated strides required to confirm.
REQ-004 SHALL have parameter max_prefetch_p, default 4, the maximum number of prefetches issued per confirmed loop.
REQ-005 SHALL have one clock; reset is asynchronous and active-high: clk_i  in  1  clock; reset_i  in  1  async active-high reset.
REQ-006 SHALL have ports, one per line:
- load_v_i  in  1  committed load valid
- load_pc_i  in  vaddr_width_p  load PC
- load_vaddr_i  in  vaddr_width_p  load effective address
- flush_i  in  1  abort request
- start_discovery_o  out  1  one-cycle pulse, new candidate
- confirm_discovery_o  out  1  one-cycle pulse, stride confirmed
- striding_pc_o  out  vaddr_width_p  candidate load PC
- iter_v_i  in  1  iteration count valid
- remaining_iterations_i  in  iter_width_p  inferred iterations left
- iter_yumi_o  out  1  count consumed
- pf_v_o  out  1  prefetch valid
- pf_vaddr_o  out  vaddr_width_p  prefetch address
- pf_ready_i  in  1  prefetch accepted
- busy_o  out  1  state != IDLE

Function
REQ-007 SHALL implement states IDLE, TRAIN, WAIT_ITER, PREFETCH.
REQ-008 IDLE, when load_v_i is high: SHALL latch pc_r, last_r = load_vaddr_i, stride_r = 0 and cnt_r = 0, then go to TRAIN.
REQ-009 TRAIN, on load_v_i with load_pc_i == pc_r: SHALL compute s = load_vaddr_i - last_r (modulo 2^vaddr_width_p) and update last_r.
REQ-010 TRAIN, if s != 0 and s == stride_r: SHALL increment cnt_r; otherwise set stride_r = s and cnt_r = 0.
REQ-011 TRAIN, if s != 0 and s != stride_r: SHALL pulse start_discovery_o in the next cycle, with striding_pc_o = pc_r.
REQ-012 TRAIN, when cnt_r reaches confirm_threshold_p: SHALL pulse confirm_discovery_o for one cycle and go to WAIT_ITER.
REQ-013 TRAIN: SHALL ignore loads with a different PC.
REQ-014 start_discovery_o and confirm_discovery_o SHALL never be asserted in the same cycle.
REQ-015 WAIT_ITER: SHALL assert iter_yumi_o combinationally in every cycle that iter_v_i is high, and capture remaining_iterations_i into n_r = min(count, max_prefetch_p).
REQ-016 WAIT_ITER: after capture, SHALL go to PREFETCH with k_r = 1, or to IDLE if n_r == 0.
REQ-017 PREFETCH: SHALL output pf_vaddr_o = last_r + k_r*stride_r (wraps) with pf_v_o held high until pf_ready_i.
REQ-018 PREFETCH: on each handshake, SHALL increment k_r; after the handshake with k_r == n_r, SHALL go to IDLE.
REQ-019 WAIT_ITER and PREFETCH: SHALL ignore all loads.
REQ-020 flush_i in TRAIN or PREFETCH SHALL go to IDLE next cycle; pf_v_o drops immediately.
REQ-021 flush_i in WAIT_ITER SHALL set drop_r; the next iter_v_i is still consumed with yumi, and then the state goes to IDLE without prefetching.
REQ-022 iter_v_i outside WAIT_ITER SHALL NOT be acknowledged.

Reset
REQ-023 Reset SHALL set state IDLE and clear all outputs, pc_r, last_r, stride_r, cnt_r, n_r, k_r and drop_r to 0.
REQ-024 Reset asserted mid-operation SHALL abort immediately; no pulse or prefetch is emitted after reset.

Configuration
REQ-025 Macro BP_BE_STRIDE_PAGE_CLAMP_EN, when defined, SHALL cause a prefetch whose address bits [vaddr_width_p-1:12] differ from last_r's to terminate PREFETCH (go IDLE, pf_v_o low) instead of being issued.
REQ-026 Without BP_BE_STRIDE_PAGE_CLAMP_EN, page crossings SHALL be unrestricted.

Structure
REQ-027 The state enum bp_be_stride_state_e SHALL reside in bp_be_pkg.
REQ-028 Address generation (last_r + k_r*stride_r, with the page clamp) SHALL be one sub-module, bp_be_stride_addr_gen; everything else stays in a single file.

Verification
REQ-029 Loads at PC 0x100, addresses 0x1000, 0x1008, 0x1010, 0x1018 -> start pulse after the 2nd load, confirm after the 4th; then iter_v_i with count 10 -> prefetches at 0x1020, 0x1028, 0x1030, 0x1038 are issued, then IDLE.
REQ-030 Strides 8, 8, 16, 16, 16 -> second start pulse on the 16 stride, cnt reset, confirm after two repeats of 16.
REQ-031 Count 2 with pf_ready_i low for 3 cycles -> pf_vaddr_o is held stable, exactly 2 prefetches are issued, yumi lasts exactly 1 cycle.
REQ-032 flush_i in WAIT_ITER, then iter_v_i -> yumi is asserted, no pf_v_o, state IDLE.
REQ-033 With the macro defined, last_r = 0x1FF8 and stride 8 -> no prefetch is issued and the block returns to IDLE; without the macro -> 0x2000 is issued.
REQ-034 Reset asserted during PREFETCH -> pf_v_o is 0 within the same cycle and busy_o is 0.
